// File: rtl/sar_pkg.sv
// sar_pkg: shared constants and state encoding for the SAR
// conversion sequencer and its round-robin arbiter.
package sar_pkg;

  localparam int SAR_DATA_W  = 10;
  localparam int SAR_TMO_CYC = 40;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_START = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set
// request at or above ptr_i, wrapping; one-hot plus encoded ID.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] id_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    idx   = '0;
    // Scan farthest-first so the nearest set request wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_i) + i) % NREQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer: round-robin conversion scheduler for the SAR core.
// Define SAR_SEQ_AVG_EN to average four conversions per grant.
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = SAR_DATA_W,
  parameter int TMO_CYC = SAR_TMO_CYC,
  parameter int TMO_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  output logic              cnvst,
  input  logic              eoc,
  input  logic [DATA_W-1:0] sar,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [ID_W-1:0]   res_id,
  output logic              res_err,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   gnt_id;
  logic [NREQ-1:0]   gnt;
  logic [TMO_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;
  logic              cnvst_q, cnvst_d;
  logic              busy_q, busy_d;
`ifdef SAR_SEQ_AVG_EN
  logic [DATA_W+1:0] acc_q, acc_d, sum;
  logic [1:0]        cnt_q, cnt_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    err_d   = err_q;
    vld_d   = vld_q;
`ifdef SAR_SEQ_AVG_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum     = acc_q + {2'b00, sar};
`endif
    unique case (state_q)
      SEQ_IDLE: begin
        if (en && |gnt) begin
          id_d    = gnt_id;
          state_d = SEQ_START;
`ifdef SAR_SEQ_AVG_EN
          acc_d   = '0;
          cnt_d   = '0;
`endif
        end
      end
      SEQ_START: begin
        tmr_d   = '0;
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        // eoc wins over a timeout landing in the same cycle.
        if (eoc) begin
`ifdef SAR_SEQ_AVG_EN
          if (cnt_q == 2'd3) begin
            data_d  = sum[DATA_W+1:2];
            err_d   = 1'b0;
            vld_d   = 1'b1;
            state_d = SEQ_DONE;
          end else begin
            acc_d   = sum;
            cnt_d   = cnt_q + 1'b1;
            state_d = SEQ_START;
          end
`else
          data_d  = sar;
          err_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = SEQ_DONE;
`endif
        end else if (tmr_q == TMO_W'(TMO_CYC - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          vld_d   = 1'b1;
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          ptr_d   = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    cnvst_d = (state_d == SEQ_START);
    busy_d  = (state_d != SEQ_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEQ_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnvst_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SAR_SEQ_AVG_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnvst_q <= cnvst_d;
      busy_q  <= busy_d;
`ifdef SAR_SEQ_AVG_EN
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cnvst     = cnvst_q;
  assign res_valid = vld_q;
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign res_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb_sar_conv_sequencer: directed and randomized checks of the sequencer
// against a transaction-timing model and a bench-side SAR core.
module tb_sar_conv_sequencer;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int DW    = 10;
  localparam int TMO   = 40;
  localparam int TMO_W = 6;
`ifdef SAR_SEQ_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            eoc = 1'b0;
  logic [DW-1:0]   sar = '0;
  logic            res_ready = 1'b0;
  logic            cnvst, res_valid, res_err, busy;
  logic [DW-1:0]   res_data;
  logic [ID_W-1:0] res_id;

  sar_conv_sequencer #(
    .NREQ(NREQ), .ID_W(ID_W), .DATA_W(DW), .TMO_CYC(TMO), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .cnvst(cnvst),
    .eoc(eoc), .sar(sar), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  longint cyc = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Model state: job slot timestamps, conversion window, rr pointer.
  bit            m_free = 1'b1;
  longint        free_from = 0;
  bit            m_done = 1'b0;
  longint        done_from = 0;
  longint        start_at = -1;
  bit            conv_act = 1'b0;
  longint        conv_start = 0;
  longint        conv_end = 0;
  bit            conv_ok = 1'b0;
  int            m_n = 0, m_acc = 0, m_id = 0, m_ptr = 0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_err = 1'b0;
  longint        eoc_at = -1;
  int            eoc_val = 0;
  bit            fr, dn, inw, pv = 1'b0;
  int            lat;

  // Bench SAR core plan.
  bit fix_mode = 1'b1;
  int fix_lat = 25;
  int fix_vals[4] = '{default: 0};
  int tmo_idx = -1;
  bit spur_en = 1'b0;

  // Observations.
  int              n_cnvst = 0, n_acc = 0;
  longint          first_cnvst_cyc = 0, valid_rise = 0;
  logic [DW-1:0]   acc_data = '0;
  logic [ID_W-1:0] acc_id = '0;
  logic            acc_err = 1'b0;
  int              id_log[$];

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int rand_lat();
    case ($urandom_range(0, 9))
      0: return 1;
      1: return TMO;
      2: return TMO + 1;
      3: return 0;
      4: return TMO + 2;
      default: return $urandom_range(2, 12);
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rst_cnvst", cnvst, 0);
      check("rst_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", res_data, 0);
      check("rst_id", res_id, 0);
      check("rst_err", res_err, 0);
      m_free = 1'b1; free_from = cyc + 1; m_done = 1'b0;
      start_at = -1; conv_act = 1'b0; m_ptr = 0; eoc_at = -1;
      pv = 1'b0; eoc = 1'b0;
    end else begin
      fr  = m_free && cyc >= free_from;
      dn  = m_done && cyc >= done_from;
      inw = conv_act && cyc > conv_start && cyc <= conv_end;
      check("cnvst", cnvst, cyc == start_at);
      check("res_valid", res_valid, dn);
      check("busy", busy, !fr);
      if (dn) begin
        check("res_data", res_data, exp_data);
        check("res_id", res_id, m_id);
        check("res_err", res_err, exp_err);
      end
      if (cnvst) begin
        n_cnvst++;
        if (m_n == 0) first_cnvst_cyc = cyc;
      end
      if (res_valid && !pv) valid_rise = cyc;
      pv = res_valid;
      if (cyc == start_at) begin
        if (fix_mode) lat = (m_n == tmo_idx) ? 0 : fix_lat;
        else lat = rand_lat();
        eoc_val = fix_mode ? fix_vals[m_n] : $urandom_range(0, 1023);
        conv_act = 1'b1; conv_start = cyc;
        conv_ok = lat >= 1 && lat <= TMO;
        conv_end = conv_ok ? cyc + lat : cyc + TMO;
        eoc_at = (lat > 0) ? cyc + lat : -1;
      end
      if (conv_act && cyc == conv_end) begin
        conv_act = 1'b0;
        if (conv_ok) begin
          m_acc += eoc_val; m_n++;
          if (m_n < NCONV) start_at = cyc + 1;
          else begin
            exp_data = DW'(m_acc / NCONV); exp_err = 1'b0;
            m_done = 1'b1; done_from = cyc + 1;
          end
        end else begin
          exp_data = '0; exp_err = 1'b1;
          m_done = 1'b1; done_from = cyc + 1;
        end
      end
      if (dn && res_ready) begin
        m_done = 1'b0; m_free = 1'b1; free_from = cyc + 1;
        m_ptr = (m_id + 1) % NREQ;
        acc_data = res_data; acc_id = res_id; acc_err = res_err;
        id_log.push_back(int'(res_id)); n_acc++;
      end
      if (fr && en && req != '0) begin
        m_id = rr_pick(req, m_ptr); start_at = cyc + 1;
        m_free = 1'b0; m_n = 0; m_acc = 0;
      end
      if (cyc == eoc_at) begin
        eoc = 1'b1; sar = DW'(eoc_val);
      end else begin
        eoc = spur_en && !inw && $urandom_range(0, 5) == 0;
        sar = DW'($urandom);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input string nm);
    int k = 0;
    while (n_acc < target && k < 800) begin
      @(posedge clk); #1; k++;
    end
    check(nm, n_acc, target);
  endtask

  int base, nacc, k;
  int fair_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    step(3);
    rst = 1'b1;
    step(1);

    // Single request, eoc 25 cycles after cnvst.
    fix_lat = 25; fix_vals = '{'h2A5, 'h2A5, 'h2A5, 'h2A5};
    base = n_cnvst; nacc = n_acc;
    req = 4'b0001; en = 1'b1; res_ready = 1'b1;
    wait_acc(nacc + 1, "t1_accept");
    req = '0;
    check("t1_cnvst_cnt", n_cnvst - base, NCONV);
    check("t1_data", acc_data, 'h2A5);
    check("t1_id", acc_id, 0);
    check("t1_err", acc_err, 0);
    check("t1_latency", valid_rise - first_cnvst_cyc, 26 * NCONV);
    step(3);

    // Fairness from a reset pointer.
    rst = 1'b0; step(1); rst = 1'b1;
    fix_lat = 3; id_log.delete();
    base = n_cnvst; nacc = n_acc;
    req = 4'b1111;
    wait_acc(nacc + 5, "t2_accept");
    req = '0;
    for (int i = 0; i < 5; i++)
      check("t2_order", (i < id_log.size()) ? id_log[i] : -1, fair_exp[i]);
    check("t2_cnvst_cnt", n_cnvst - base, 5 * NCONV);
    step(3);

    // Timeout, then a normal grant.
    tmo_idx = 0; nacc = n_acc;
    req = 4'b0001;
    wait_acc(nacc + 1, "t3_accept");
    req = '0;
    check("t3_err", acc_err, 1);
    check("t3_data", acc_data, 0);
    check("t3_latency", valid_rise - first_cnvst_cyc, TMO + 1);
    tmo_idx = -1; fix_vals = '{'h155, 'h155, 'h155, 'h155};
    nacc = n_acc; req = 4'b0010;
    wait_acc(nacc + 1, "t3b_accept");
    req = '0;
    check("t3b_err", acc_err, 0);
    check("t3b_data", acc_data, 'h155);
    check("t3b_id", acc_id, 1);
    step(3);

    // Backpressure with en dropped during DONE.
    fix_lat = 5; fix_vals = '{'h0F0, 'h0F0, 'h0F0, 'h0F0};
    req = 4'b0100; res_ready = 1'b0;
    k = 0;
    while (!res_valid && k < 400) begin step(1); k++; end
    check("t4_valid", res_valid, 1);
    en = 1'b0; req = 4'b1111; base = n_cnvst;
    step(10);
    check("t4_hold_cnvst", n_cnvst - base, 0);
    check("t4_hold_valid", res_valid, 1);
    check("t4_hold_data", res_data, 'h0F0);
    check("t4_hold_id", res_id, 2);
    res_ready = 1'b1; step(1); res_ready = 1'b0;
    step(8);
    check("t4_idle_cnvst", n_cnvst - base, 0);
    check("t4_idle_busy", busy, 0);
    nacc = n_acc; en = 1'b1; res_ready = 1'b1;
    wait_acc(nacc + 1, "t4_accept");
    req = '0;
    check("t4_next_id", acc_id, 3);
    step(3);

    // Async reset mid-WAIT clears the pointer and drops the job.
    fix_lat = 4; fix_vals = '{'h111, 'h111, 'h111, 'h111};
    nacc = n_acc; req = 4'b0010;
    wait_acc(nacc + 1, "t5a_accept");
    req = '0;
    check("t5a_id", acc_id, 1);
    step(2);
    fix_lat = 30; base = n_cnvst; req = 4'b0100;
    k = 0;
    while (n_cnvst == base && k < 100) begin step(1); k++; end
    check("t5_started", n_cnvst - base, 1);
    step(10);
    rst = 1'b0; #1;
    check("t5_rst_cnvst", cnvst, 0);
    check("t5_rst_valid", res_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_data", res_data, 0);
    check("t5_rst_id", res_id, 0);
    check("t5_rst_err", res_err, 0);
    req = '0;
    @(posedge clk); #1; rst = 1'b1;
    nacc = n_acc;
    step(50);
    check("t5_no_stale", n_acc - nacc, 0);
    fix_lat = 4; req = 4'b1111;
    wait_acc(nacc + 1, "t5b_accept");
    req = '0;
    check("t5b_id", acc_id, 0);
    step(3);

`ifdef SAR_SEQ_AVG_EN
    // Averaging: four results, then a timeout on the third.
    fix_lat = 7; fix_vals = '{100, 101, 102, 104};
    base = n_cnvst; nacc = n_acc; req = 4'b0001;
    wait_acc(nacc + 1, "t6_accept");
    req = '0;
    check("t6_data", acc_data, 101);
    check("t6_err", acc_err, 0);
    check("t6_cnvst_cnt", n_cnvst - base, 4);
    step(3);
    tmo_idx = 2; base = n_cnvst; nacc = n_acc; req = 4'b0001;
    wait_acc(nacc + 1, "t6b_accept");
    req = '0;
    check("t6b_err", acc_err, 1);
    check("t6b_data", acc_data, 0);
    check("t6b_cnvst_cnt", n_cnvst - base, 3);
    tmo_idx = -1;
    step(3);
`endif

    // Randomized traffic with spurious eoc and rare resets.
    fix_mode = 1'b0; spur_en = 1'b1; nacc = n_acc;
    for (int i = 0; i < 3000; i++) begin
      req = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      en = ($urandom_range(0, 7) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rst = 1'b1; req = '0; en = 1'b0; res_ready = 1'b1; spur_en = 1'b0;
    check("rand_progress", n_acc > nacc + 20, 1);
    step(100);
    check("drain_busy", busy, 0);
    check("drain_valid", res_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

endmodule
